// File: rtl/sram_arbiter_pkg.sv
// Shared bus defines and arbiter types used by the SRAM arbiter and its slot sub-module.
`ifndef SRAM_ARBITER_BUS_DEFINES
`define SRAM_ARBITER_BUS_DEFINES
`define BUS_WIDTH      32
`define BUS_ACC_WIDTH  2
`define BUS_ACC_1B     2'b00
`define BUS_ACC_2B     2'b01
`define BUS_ACC_4B     2'b10
`define SRAM_VA_WIDTH  19
`endif

package sram_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Tie-break: round-robin hands the grant to the master that did not win last.
    function automatic logic arb_pick(input logic i_c0, input logic i_c1,
                                      input logic i_rr, input logic i_last);
        logic w_win;
        if (i_c0 && i_c1) begin
            w_win = i_rr ? ~i_last : M1;
        end else if (i_c1) begin
            w_win = M1;
        end else begin
            w_win = M0;
        end
        return w_win;
    endfunction

endpackage

// File: rtl/sram_arbiter_slot.sv
// Single-entry pending-request capture register for one master.
module sram_arb_slot
    import sram_arbiter_pkg::*;
#(
    parameter int AW = `SRAM_VA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_req,
    input  logic                      i_load,
    input  logic                      i_clr,
    input  logic [AW-1:0]             i_addr,
    input  logic                      i_w_rb,
    input  logic [`BUS_ACC_WIDTH-1:0] i_acc,
    input  logic [`BUS_WIDTH-1:0]     i_wdata,
    output logic                      o_full,
    output logic                      o_drop,
    output logic [AW-1:0]             o_addr,
    output logic                      o_w_rb,
    output logic [`BUS_ACC_WIDTH-1:0] o_acc,
    output logic [`BUS_WIDTH-1:0]     o_wdata
);

    logic                      r_full;
    logic [AW-1:0]             r_addr;
    logic                      r_w_rb;
    logic [`BUS_ACC_WIDTH-1:0] r_acc;
    logic [`BUS_WIDTH-1:0]     r_wdata;

    // Clear wins over load; fields are only written when a request is parked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full  <= 1'b0;
            r_addr  <= '0;
            r_w_rb  <= 1'b0;
            r_acc   <= '0;
            r_wdata <= '0;
        end else if (i_clr) begin
            r_full  <= 1'b0;
        end else if (i_load) begin
            r_full  <= 1'b1;
            r_addr  <= i_addr;
            r_w_rb  <= i_w_rb;
            r_acc   <= i_acc;
            r_wdata <= i_wdata;
        end else begin
            r_full  <= r_full;
        end
    end

    assign o_full  = r_full;
    assign o_drop  = i_req & r_full;
    assign o_addr  = r_addr;
    assign o_w_rb  = r_w_rb;
    assign o_acc   = r_acc;
    assign o_wdata = r_wdata;

endmodule

// File: rtl/sram_arbiter.sv
// Two-master arbiter in front of a single-outstanding SRAM controller user interface.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int AW = `SRAM_VA_WIDTH,
    parameter int RR = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AW-1:0]             m0_addr,
    input  logic [AW-1:0]             m1_addr,
    input  logic                      m0_w_rb,
    input  logic                      m1_w_rb,
    input  logic [`BUS_ACC_WIDTH-1:0] m0_acc,
    input  logic [`BUS_ACC_WIDTH-1:0] m1_acc,
    input  logic [`BUS_WIDTH-1:0]     m0_wdata,
    input  logic [`BUS_WIDTH-1:0]     m1_wdata,
    input  logic                      m0_req,
    input  logic                      m1_req,
    output logic                      m0_resp,
    output logic                      m1_resp,
    output logic                      m0_fault,
    output logic                      m1_fault,
    output logic [`BUS_WIDTH-1:0]     m_rdata,
    output logic [AW-1:0]             s_addr,
    output logic                      s_w_rb,
    output logic [`BUS_ACC_WIDTH-1:0] s_acc,
    output logic [`BUS_WIDTH-1:0]     s_wdata,
    output logic                      s_req,
    input  logic [`BUS_WIDTH-1:0]     s_rdata,
    input  logic                      s_resp,
    input  logic                      s_fault
);

    arb_state_t r_state, w_state_nxt;
    logic       r_owner, w_owner_nxt;
    logic       r_last, w_last_nxt;
    logic       r_boot;

    logic [1:0] w_req, w_drop, w_busy, w_viol, w_live, w_cand, w_full, w_load, w_clr;
    logic       w_in_wait, w_issue, w_win;

    logic [AW-1:0]             w_in_addr   [2];
    logic                      w_in_w_rb   [2];
    logic [`BUS_ACC_WIDTH-1:0] w_in_acc    [2];
    logic [`BUS_WIDTH-1:0]     w_in_wdata  [2];
    logic [AW-1:0]             w_slot_addr [2];
    logic                      w_slot_w_rb [2];
    logic [`BUS_ACC_WIDTH-1:0] w_slot_acc  [2];
    logic [`BUS_WIDTH-1:0]     w_slot_wdata[2];

    assign w_req         = {m1_req, m0_req};
    assign w_in_addr[0]  = m0_addr;
    assign w_in_addr[1]  = m1_addr;
    assign w_in_w_rb[0]  = m0_w_rb;
    assign w_in_w_rb[1]  = m1_w_rb;
    assign w_in_acc[0]   = m0_acc;
    assign w_in_acc[1]   = m1_acc;
    assign w_in_wdata[0] = m0_wdata;
    assign w_in_wdata[1] = m1_wdata;

    for (genvar g = 0; g < 2; g++) begin : g_slot
        sram_arb_slot #(.AW(AW)) u_slot (
            .clk     (clk),
            .rst     (rst),
            .i_req   (w_req[g]),
            .i_load  (w_load[g]),
            .i_clr   (w_clr[g]),
            .i_addr  (w_in_addr[g]),
            .i_w_rb  (w_in_w_rb[g]),
            .i_acc   (w_in_acc[g]),
            .i_wdata (w_in_wdata[g]),
            .o_full  (w_full[g]),
            .o_drop  (w_drop[g]),
            .o_addr  (w_slot_addr[g]),
            .o_w_rb  (w_slot_w_rb[g]),
            .o_acc   (w_slot_acc[g]),
            .o_wdata (w_slot_wdata[g])
        );
    end

    // A master completing this cycle may already request its next access.
    always_comb begin
        w_in_wait       = (r_state == ST_WAIT);
        w_busy          = 2'b00;
        w_busy[r_owner] = w_in_wait && !s_resp;
        w_viol          = w_drop | (w_req & w_busy);
        w_live          = w_req & ~w_viol;
        w_cand          = w_full | w_live;
        w_issue         = !rst && !r_boot && (!w_in_wait || s_resp) && (w_cand != 2'b00);
        w_win           = arb_pick(w_cand[0], w_cand[1], (RR != 0), r_last);
        w_load          = w_live;
        w_clr           = 2'b00;
        if (w_issue) begin
            w_load[w_win] = 1'b0;
            w_clr[w_win]  = 1'b1;
        end else begin
            w_clr = 2'b00;
        end
    end

    // Winner's parked request takes precedence over whatever is on its live inputs.
    always_comb begin
        s_req   = w_issue;
        s_addr  = '0;
        s_w_rb  = 1'b0;
        s_acc   = '0;
        s_wdata = '0;
        if (w_issue) begin
            if (w_full[w_win]) begin
                s_addr  = w_slot_addr[w_win];
                s_w_rb  = w_slot_w_rb[w_win];
                s_acc   = w_slot_acc[w_win];
                s_wdata = w_slot_wdata[w_win];
            end else begin
                s_addr  = w_in_addr[w_win];
                s_w_rb  = w_in_w_rb[w_win];
                s_acc   = w_in_acc[w_win];
                s_wdata = w_in_wdata[w_win];
            end
        end else begin
            s_req = 1'b0;
        end
    end

    assign m0_fault = !rst && (w_viol[0] || (w_issue && s_fault && (w_win == M0)));
    assign m1_fault = !rst && (w_viol[1] || (w_issue && s_fault && (w_win == M1)));
    assign m0_resp  = !rst && w_in_wait && s_resp && (r_owner == M0);
    assign m1_resp  = !rst && w_in_wait && s_resp && (r_owner == M1);
    assign m_rdata  = rst ? '0 : s_rdata;

    // A rejected issue keeps the FSM where it was unless the outstanding access also completed.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        if (w_issue) begin
            w_last_nxt = w_win;
            if (!s_fault) begin
                w_state_nxt = ST_WAIT;
                w_owner_nxt = w_win;
            end else if (w_in_wait && s_resp) begin
                w_state_nxt = ST_IDLE;
            end else begin
                w_state_nxt = r_state;
            end
        end else if (w_in_wait && s_resp) begin
            w_state_nxt = ST_IDLE;
        end else begin
            w_state_nxt = r_state;
        end
    end

    // State, owner, last grant and the post-reset issue blocker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= M0;
            r_last  <= M1;
            r_boot  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_boot  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench: a round-robin and a fixed-priority arbiter share the slave-side inputs.
module tb_sram_arbiter;

    localparam logic [2:0] EV_F0 = 3'd0;
    localparam logic [2:0] EV_F1 = 3'd1;
    localparam logic [2:0] EV_IS = 3'd2;
    localparam logic [2:0] EV_R0 = 3'd3;
    localparam logic [2:0] EV_R1 = 3'd4;

    typedef struct packed {
        logic [2:0]  kind;
        logic [18:0] addr;
        logic        w;
        logic [1:0]  acc;
        logic [31:0] data;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [18:0] m0_addr = '0, m1_addr = '0;
    logic        m0_w_rb = 1'b0, m1_w_rb = 1'b0;
    logic [1:0]  m0_acc = '0, m1_acc = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic        m0_req_a = 1'b0, m1_req_a = 1'b0, m0_req_b = 1'b0, m1_req_b = 1'b0;
    logic [31:0] s_rdata = '0;
    logic        s_resp = 1'b0, s_fault = 1'b0;

    logic        a_m0_resp, a_m1_resp, a_m0_fault, a_m1_fault, a_s_w_rb, a_s_req;
    logic [31:0] a_m_rdata, a_s_wdata;
    logic [18:0] a_s_addr;
    logic [1:0]  a_s_acc;
    logic        b_m0_resp, b_m1_resp, b_m0_fault, b_m1_fault, b_s_w_rb, b_s_req;
    logic [31:0] b_m_rdata, b_s_wdata;
    logic [18:0] b_s_addr;
    logic [1:0]  b_s_acc;

    always #5 clk = ~clk;

    sram_arbiter #(.AW(19), .RR(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_w_rb(m0_w_rb), .m1_w_rb(m1_w_rb),
        .m0_acc(m0_acc), .m1_acc(m1_acc), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_req(m0_req_a), .m1_req(m1_req_a),
        .m0_resp(a_m0_resp), .m1_resp(a_m1_resp), .m0_fault(a_m0_fault), .m1_fault(a_m1_fault),
        .m_rdata(a_m_rdata), .s_addr(a_s_addr), .s_w_rb(a_s_w_rb), .s_acc(a_s_acc),
        .s_wdata(a_s_wdata), .s_req(a_s_req),
        .s_rdata(s_rdata), .s_resp(s_resp), .s_fault(s_fault)
    );

    sram_arbiter #(.AW(19), .RR(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_w_rb(m0_w_rb), .m1_w_rb(m1_w_rb),
        .m0_acc(m0_acc), .m1_acc(m1_acc), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_req(m0_req_b), .m1_req(m1_req_b),
        .m0_resp(b_m0_resp), .m1_resp(b_m1_resp), .m0_fault(b_m0_fault), .m1_fault(b_m1_fault),
        .m_rdata(b_m_rdata), .s_addr(b_s_addr), .s_w_rb(b_s_w_rb), .s_acc(b_s_acc),
        .s_wdata(b_s_wdata), .s_req(b_s_req),
        .s_rdata(s_rdata), .s_resp(s_resp), .s_fault(s_fault)
    );

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic chk(input int sel, input logic [2:0] kind, input logic [18:0] addr,
                       input logic w, input logic [1:0] acc, input logic [31:0] data);
        exp_t e;
        logic ok;
        n_tests++;
        if ((sel == 0 && q_a.size() == 0) || (sel == 1 && q_b.size() == 0)) begin
            n_fail++;
            $display("FAIL dut%0d unexpected event: got kind %0d addr %h w %0d acc %0d data %h, required none",
                     sel, kind, addr, w, acc, data);
        end else begin
            if (sel == 0) e = q_a.pop_front();
            else          e = q_b.pop_front();
            ok = (e.kind == kind);
            if (kind == EV_IS)
                ok = ok && (e.addr == addr) && (e.w == w) && (e.acc == acc) && (e.data == data);
            else if (kind >= EV_R0)
                ok = ok && (e.data == data);
            if (!ok) begin
                n_fail++;
                $display("FAIL dut%0d event: got kind %0d addr %h w %0d acc %0d data %h, required kind %0d addr %h w %0d acc %0d data %h",
                         sel, kind, addr, w, acc, data, e.kind, e.addr, e.w, e.acc, e.data);
            end
        end
    endtask

    // Monitor: per cycle, events are taken in the order F0, F1, issue, R0, R1.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_m0_fault) chk(0, EV_F0, 19'h0, 1'b0, 2'b00, 32'h0);
            if (a_m1_fault) chk(0, EV_F1, 19'h0, 1'b0, 2'b00, 32'h0);
            if (a_s_req) chk(0, EV_IS, a_s_addr, a_s_w_rb, a_s_acc, a_s_wdata);
            else cmp("dut0 s_fields_idle", {10'h0, a_s_addr, a_s_w_rb, a_s_acc, a_s_wdata}, 64'h0);
            if (a_m0_resp) chk(0, EV_R0, 19'h0, 1'b0, 2'b00, a_m_rdata);
            if (a_m1_resp) chk(0, EV_R1, 19'h0, 1'b0, 2'b00, a_m_rdata);
            if (b_m0_fault) chk(1, EV_F0, 19'h0, 1'b0, 2'b00, 32'h0);
            if (b_m1_fault) chk(1, EV_F1, 19'h0, 1'b0, 2'b00, 32'h0);
            if (b_s_req) chk(1, EV_IS, b_s_addr, b_s_w_rb, b_s_acc, b_s_wdata);
            else cmp("dut1 s_fields_idle", {10'h0, b_s_addr, b_s_w_rb, b_s_acc, b_s_wdata}, 64'h0);
            if (b_m0_resp) chk(1, EV_R0, 19'h0, 1'b0, 2'b00, b_m_rdata);
            if (b_m1_resp) chk(1, EV_R1, 19'h0, 1'b0, 2'b00, b_m_rdata);
        end
    end

    task automatic ei(input int sel, input logic [18:0] addr, input logic w,
                      input logic [1:0] acc, input logic [31:0] data);
        exp_t e;
        e = '{kind: EV_IS, addr: addr, w: w, acc: acc, data: data};
        if (sel == 0) q_a.push_back(e);
        else          q_b.push_back(e);
    endtask

    task automatic ee(input int sel, input logic [2:0] kind, input logic [31:0] data);
        exp_t e;
        e = '{kind: kind, addr: 19'h0, w: 1'b0, acc: 2'b00, data: data};
        if (sel == 0) q_a.push_back(e);
        else          q_b.push_back(e);
    endtask

    task automatic drv_m0(input logic [18:0] a, input logic w, input logic [1:0] acc, input logic [31:0] d);
        m0_addr = a; m0_w_rb = w; m0_acc = acc; m0_wdata = d;
    endtask

    task automatic drv_m1(input logic [18:0] a, input logic w, input logic [1:0] acc, input logic [31:0] d);
        m1_addr = a; m1_w_rb = w; m1_acc = acc; m1_wdata = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        m0_req_a = 1'b0; m1_req_a = 1'b0; m0_req_b = 1'b0; m1_req_b = 1'b0;
        s_resp = 1'b0; s_fault = 1'b0;
    endtask

    task automatic slave_resp(input logic [31:0] d);
        s_resp = 1'b1; s_rdata = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset: outputs stay low even with a live request present.
        m0_req_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cmp("reset s_req", {63'h0, a_s_req}, 64'h0);
        cmp("reset m0_resp", {63'h0, a_m0_resp}, 64'h0);
        cmp("reset m1_resp", {63'h0, a_m1_resp}, 64'h0);
        cmp("reset m0_fault", {63'h0, a_m0_fault}, 64'h0);
        cmp("reset m1_fault", {63'h0, a_m1_fault}, 64'h0);
        m0_req_a = 1'b0;
        rst = 1'b0;
        tick();

        // Single 4B read from m0.
        drv_m0(19'h100, 1'b0, `BUS_ACC_4B, 32'h0); m0_req_a = 1'b1;
        ei(0, 19'h100, 1'b0, `BUS_ACC_4B, 32'h0);
        tick();
        slave_resp(32'hDEADBEEF); ee(0, EV_R0, 32'hDEADBEEF);
        tick();

        // Tie after reset under round-robin.
        rst = 1'b1; tick(); rst = 1'b0; tick();
        drv_m0(19'h10, 1'b0, `BUS_ACC_4B, 32'h0); m0_req_a = 1'b1;
        drv_m1(19'h20, 1'b1, `BUS_ACC_4B, 32'h11112222); m1_req_a = 1'b1;
        ei(0, 19'h10, 1'b0, `BUS_ACC_4B, 32'h0);
        tick();
        slave_resp(32'hA5A5A5A5);
        ei(0, 19'h20, 1'b1, `BUS_ACC_4B, 32'h11112222); ee(0, EV_R0, 32'hA5A5A5A5);
        tick();
        slave_resp(32'h12345678);
        drv_m0(19'h30, 1'b0, `BUS_ACC_2B, 32'h0); m0_req_a = 1'b1;
        drv_m1(19'h40, 1'b0, `BUS_ACC_1B, 32'h0); m1_req_a = 1'b1;
        ei(0, 19'h30, 1'b0, `BUS_ACC_2B, 32'h0); ee(0, EV_R1, 32'h12345678);
        tick();
        slave_resp(32'h0BADF00D);
        drv_m1(19'h7FFFF, 1'b1, `BUS_ACC_4B, 32'hFFFFFFFF);
        ei(0, 19'h40, 1'b0, `BUS_ACC_1B, 32'h0); ee(0, EV_R0, 32'h0BADF00D);
        tick();
        slave_resp(32'h55AA55AA); ee(0, EV_R1, 32'h55AA55AA);
        tick();

        // Slave rejects a write; the arbiter stays idle and can issue at once.
        drv_m1(19'h2, 1'b1, `BUS_ACC_4B, 32'hCAFEF00D); m1_req_a = 1'b1; s_fault = 1'b1;
        ee(0, EV_F1, 32'h0); ei(0, 19'h2, 1'b1, `BUS_ACC_4B, 32'hCAFEF00D);
        tick();
        drv_m0(19'h44, 1'b0, `BUS_ACC_1B, 32'h0); m0_req_a = 1'b1;
        ei(0, 19'h44, 1'b0, `BUS_ACC_1B, 32'h0);
        tick();
        slave_resp(32'h000000EE); ee(0, EV_R0, 32'h000000EE);
        tick();

        // Owner re-requests while its access is outstanding.
        drv_m0(19'h50, 1'b0, `BUS_ACC_2B, 32'h0); m0_req_a = 1'b1;
        ei(0, 19'h50, 1'b0, `BUS_ACC_2B, 32'h0);
        tick();
        drv_m0(19'h54, 1'b1, `BUS_ACC_4B, 32'h99); m0_req_a = 1'b1; ee(0, EV_F0, 32'h0);
        tick();
        drv_m0(19'h58, 1'b0, `BUS_ACC_4B, 32'h0); m0_req_a = 1'b1; ee(0, EV_F0, 32'h0);
        tick();
        slave_resp(32'h00000001); ee(0, EV_R0, 32'h00000001);
        tick();
        tick();

        // Reset while waiting with m1 parked.
        drv_m0(19'h60, 1'b0, `BUS_ACC_4B, 32'h0); m0_req_a = 1'b1;
        ei(0, 19'h60, 1'b0, `BUS_ACC_4B, 32'h0);
        tick();
        drv_m1(19'h70, 1'b1, `BUS_ACC_4B, 32'h70707070); m1_req_a = 1'b1;
        tick();
        m0_req_a = 1'b1; s_resp = 1'b1; rst = 1'b1;
        #1;
        cmp("midreset s_req", {63'h0, a_s_req}, 64'h0);
        cmp("midreset m0_resp", {63'h0, a_m0_resp}, 64'h0);
        cmp("midreset m1_resp", {63'h0, a_m1_resp}, 64'h0);
        cmp("midreset m0_fault", {63'h0, a_m0_fault}, 64'h0);
        cmp("midreset m1_fault", {63'h0, a_m1_fault}, 64'h0);
        tick();
        rst = 1'b0;
        drv_m1(19'h80, 1'b0, `BUS_ACC_2B, 32'h0); m1_req_a = 1'b1;
        tick();
        ei(0, 19'h80, 1'b0, `BUS_ACC_2B, 32'h0);
        tick();
        slave_resp(32'h80808080); ee(0, EV_R1, 32'h80808080);
        tick();

        // Fixed priority: m1 keeps winning while m0 waits in its slot.
        drv_m0(19'h90, 1'b1, `BUS_ACC_4B, 32'h90909090); m0_req_b = 1'b1;
        drv_m1(19'hA0, 1'b0, `BUS_ACC_4B, 32'h0); m1_req_b = 1'b1;
        ei(1, 19'hA0, 1'b0, `BUS_ACC_4B, 32'h0);
        tick();
        slave_resp(32'h0000A0A0);
        drv_m0(19'h91, 1'b0, `BUS_ACC_1B, 32'h0);
        drv_m1(19'hA4, 1'b0, `BUS_ACC_4B, 32'h0); m1_req_b = 1'b1;
        ei(1, 19'hA4, 1'b0, `BUS_ACC_4B, 32'h0); ee(1, EV_R1, 32'h0000A0A0);
        tick();
        slave_resp(32'h0000A4A4);
        drv_m0(19'h94, 1'b0, `BUS_ACC_1B, 32'h0); m0_req_b = 1'b1;
        drv_m1(19'hA8, 1'b0, `BUS_ACC_4B, 32'h0); m1_req_b = 1'b1;
        ee(1, EV_F0, 32'h0); ei(1, 19'hA8, 1'b0, `BUS_ACC_4B, 32'h0); ee(1, EV_R1, 32'h0000A4A4);
        tick();
        slave_resp(32'h0000A8A8);
        ei(1, 19'h90, 1'b1, `BUS_ACC_4B, 32'h90909090); ee(1, EV_R1, 32'h0000A8A8);
        tick();
        slave_resp(32'h00009090); ee(1, EV_R0, 32'h00009090);
        tick();
        tick();
        tick();

        cmp("dut0 leftover expectations", 64'(q_a.size()), 64'h0);
        cmp("dut1 leftover expectations", 64'(q_b.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 19: byte-address width, equal to `SRAM_VA_WIDTH.
REQ-002 SHALL have parameter RR, default 1: 1 means round-robin; 0 means fixed priority to m1.
REQ-003 SHALL have port clk  in  1: single clock, below 100 MHz.
REQ-004 SHALL have port rst  in  1: asynchronous, active-high reset.
REQ-005 SHALL have ports m0_addr/m1_addr  in  AW: master byte address (m0 = instruction bus, m1 = data bus).
REQ-006 SHALL have ports m0_w_rb/m1_w_rb  in  1: 1 means write, 0 means read.
REQ-007 SHALL have ports m0_acc/m1_acc  in  `BUS_ACC_WIDTH: access size, 1B, 2B or 4B.
REQ-008 SHALL have ports m0_wdata/m1_wdata  in  `BUS_WIDTH: write data.
REQ-009 SHALL have ports m0_req/m1_req  in  1: single-cycle request pulse.
REQ-010 SHALL have ports m0_resp/m1_resp  out  1: completion pulse.
REQ-011 SHALL have ports m0_fault/m1_fault  out  1: rejection pulse.
REQ-012 SHALL have port m_rdata  out  `BUS_WIDTH: read data, shared by both masters and valid when m*_resp is high.
REQ-013 SHALL have ports s_addr/s_w_rb/s_acc/s_wdata/s_req  out: drive the SRAM controller user interface.
REQ-014 SHALL have ports s_rdata/s_resp/s_fault  in: returned by the SRAM controller; s_fault is combinational in the same cycle as s_req.

Function
REQ-015 SHALL hold one pending slot per master: a master request that is not issued in the cycle it arrives SHALL be captured as addr, w_rb, acc and wdata.
REQ-016 SHALL keep a 2-state FSM: IDLE (nothing outstanding) and WAIT (one access outstanding; owner bit records the master).
REQ-017 SHALL treat a master as a candidate when its req is high or its slot is full.
REQ-018 SHALL issue when the FSM is in IDLE, or in WAIT with s_resp high (zero-bubble back-to-back), and at least one candidate exists.
REQ-019 On issue, SHALL drive s_req high for exactly one cycle together with the winner's fields: slot contents if the slot is full, otherwise the live inputs.
REQ-020 With RR=1 and both masters as candidates, SHALL grant the master not granted last; the last-grant register resets to m1, so m0 wins the first tie.
REQ-021 With RR=0 and both masters as candidates, SHALL always grant m1.
REQ-022 On issue with s_fault low: SHALL move to WAIT, set owner to the winner, and clear the winner's slot.
REQ-023 On issue with s_fault high: SHALL pulse mX_fault of the winner in the same cycle, clear its slot, and leave the FSM and owner unchanged unless s_resp was also high.
REQ-024 SHALL assert mX_resp = s_resp AND (owner == X) AND WAIT, and SHALL pass m_rdata = s_rdata unregistered.
REQ-025 With s_resp in WAIT and no issue in the same cycle, SHALL return to IDLE.
REQ-026 Protocol violation: if mX_req arrives while X's slot is full or X owns the outstanding access, SHALL drop the request and pulse mX_fault in the same cycle, leaving other state untouched.
REQ-027 Requests from both masters in the same cycle SHALL follow the tie rule: the loser is captured into its slot.
REQ-028 s_resp or s_fault arriving in IDLE SHALL be ignored.
REQ-029 SHALL drive the s_* fields to zero whenever s_req is low.

Reset
REQ-030 SHALL asynchronously force, on rst: FSM=IDLE, owner=0, last-grant=m1, both slots empty, and s_req, m0/m1_resp and m0/m1_fault all 0.
REQ-031 Reset mid-operation SHALL discard the outstanding access and pending slots with no resp or fault emitted; the integration resets the SRAM controller from the same source.
REQ-032 SHALL not issue on the first clock edge after rst deasserts.

Structure
REQ-033 The shared bus defines header SHALL contain `BUS_WIDTH=32, `BUS_ACC_WIDTH=2, the `BUS_ACC_1B/2B/4B encodings, and `SRAM_VA_WIDTH=19.
REQ-034 SHALL instantiate one sub-module, sram_arb_slot, twice: a single-entry capture register with full flag, load and clear inputs, and a drop-detect output.

Verification
REQ-035 m0 reads 4B at address 0x100, m1 idle -> s_req in the same cycle with s_addr=0x100; m0_resp with s_resp; m_rdata=0xDEADBEEF.
REQ-036 m0 and m1 request in the same cycle, RR=1, after reset -> m0 issued first; m1 issued in m0's s_resp cycle; the next tie is granted to m0 again.
REQ-037 m1 writes 4B at address 0x2, and the slave raises s_fault -> m1_fault pulse in the same cycle; FSM remains IDLE; no m1_resp.
REQ-038 m0 requests twice while its first request is outstanding -> m0_fault on the second request; exactly one m0_resp.
REQ-039 rst asserted while in WAIT with m1's slot full -> all outputs 0 immediately; no s_req for 1 cycle after release.
REQ-040 RR=0 with m0 and m1 continuously requesting -> m1 is always granted; m0 stays pending in its slot.
